// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the 8x32 register file write-back path.
// Half-enable encodings are {high, low} lane enables.
package regfile_wb_pkg;

    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    typedef enum logic [1:0] {
        HALF_NONE = 2'b00,
        HALF_LO   = 2'b01,
        HALF_HI   = 2'b10,
        HALF_WORD = 2'b11
    } half_t;

    typedef struct packed {
        reg_addr_t wa;
        half_t     half;
    } ldq_entry_t;

    // A half-word load arrives in the low 16 bits; replicate it so it lands in whichever lane is enabled.
    function automatic reg_data_t align_load(input half_t half, input reg_data_t data);
        return (half == HALF_WORD) ? data : {2{data[DATA_W/2-1:0]}};
    endfunction

endpackage

// File: rtl/regfile_wb_ldq.sv
// In-order queue of outstanding load destinations {wa, half}, with a
// per-register pending vector OR-reduced over the valid entries.
module regfile_wb_ldq
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  ldq_entry_t          push_entry,
    input  logic                pop,
    output ldq_entry_t          head,
    output logic                full,
    output logic                empty,
    output logic [NUM_REGS-1:0] pending
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0]    wr_ptr, rd_ptr, count;
    logic [DEPTH-1:0] valid;
    ldq_entry_t       slots [DEPTH];

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [IW-1:0] slot_idx(input logic [PW-1:0] p);
        return IW'(p % DEPTH);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every state update sees pre-edge values regardless of statement order.
            if (push) begin
                valid[slot_idx(wr_ptr)] <= 1'b1;
                wr_ptr                  <= next_ptr(wr_ptr);
            end
            if (pop) begin
                valid[slot_idx(rd_ptr)] <= 1'b0;
                rd_ptr                  <= next_ptr(rd_ptr);
            end
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // NOTE: slot storage has no reset; the valid bits alone decide which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push)
            slots[slot_idx(wr_ptr)] <= push_entry;
    end

    assign head  = slots[slot_idx(rd_ptr)];
    assign full  = (count == PW'(DEPTH));
    assign empty = (count == '0);

    // NOTE: default first so no path through the loop leaves pending unassigned (no latch).
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i])
                pending[slots[i].wa] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb.sv
// Register file write-back: arbitrates ALU results over load responses,
// drives the registered write port and flags pending-load hazards.
module regfile_wb
    import regfile_wb_pkg::*;
#(
    parameter int LDQ_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ALU_VALID,
    input  logic [ADDR_W-1:0] ALU_WA,
    input  logic [DATA_W-1:0] ALU_DATA,
    input  logic [1:0]        ALU_HALF,
    input  logic              LD_ISSUE,
    input  logic [ADDR_W-1:0] LD_IWA,
    input  logic [1:0]        LD_IHALF,
    input  logic              LD_RVALID,
    input  logic [DATA_W-1:0] LD_RDATA,
    output logic              LD_RREADY,
    input  logic [ADDR_W-1:0] RA0,
    input  logic [ADDR_W-1:0] RA1,
    output logic              HAZ0,
    output logic              HAZ1,
    output logic              ALU_WAW,
    output logic              LD_FULL,
    output logic              ERR,
    output logic [ADDR_W-1:0] WA,
    output logic [DATA_W-1:0] IN,
    output logic              WE_L,
    output logic              WE_H
);

    logic                rsp_accept, ldq_push, ldq_pop, ldq_full, ldq_empty, err_set;
    ldq_entry_t          head;
    logic [NUM_REGS-1:0] pending;

    assign LD_RREADY  = !ALU_VALID;
    assign rsp_accept = LD_RVALID && LD_RREADY;
    assign ldq_push   = LD_ISSUE && !ldq_full && (LD_IHALF != HALF_NONE);
    assign ldq_pop    = rsp_accept && !ldq_empty;

    // A full queue drops the issue even if a pop frees a slot in the same cycle.
    assign err_set = (LD_ISSUE && (ldq_full || LD_IHALF == HALF_NONE)) ||
                     (rsp_accept && ldq_empty);

    regfile_wb_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
        .clk        (CLK),
        .rst        (RST),
        .push       (ldq_push),
        .push_entry ('{wa: LD_IWA, half: half_t'(LD_IHALF)}),
        .pop        (ldq_pop),
        .head       (head),
        .full       (ldq_full),
        .empty      (ldq_empty),
        .pending    (pending)
    );

    assign HAZ0    = pending[RA0];
    assign HAZ1    = pending[RA1];
    assign ALU_WAW = ALU_VALID && pending[ALU_WA];
    assign LD_FULL = ldq_full;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            WA   <= '0;
            IN   <= '0;
            WE_L <= 1'b0;
            WE_H <= 1'b0;
            ERR  <= 1'b0;
        end else begin
            if (err_set)
                ERR <= 1'b1;
            if (ALU_VALID) begin
                WA   <= ALU_WA;
                IN   <= ALU_DATA;
                WE_L <= ALU_HALF[0];
                WE_H <= ALU_HALF[1];
            end else if (ldq_pop) begin
                WA   <= head.wa;
                IN   <= align_load(head.half, LD_RDATA);
                WE_L <= head.half[0];
                WE_H <= head.half[1];
            end else begin
                WE_L <= 1'b0;
                WE_H <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: hand-computed expectations for ALU writes,
// load queue ordering, hazards, protocol errors and asynchronous reset.
module tb_regfile_wb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ALU_VALID;
    logic [2:0]  ALU_WA;
    logic [31:0] ALU_DATA;
    logic [1:0]  ALU_HALF;
    logic        LD_ISSUE;
    logic [2:0]  LD_IWA;
    logic [1:0]  LD_IHALF;
    logic        LD_RVALID;
    logic [31:0] LD_RDATA;
    logic        LD_RREADY;
    logic [2:0]  RA0, RA1;
    logic        HAZ0, HAZ1, ALU_WAW, LD_FULL, ERR;
    logic [2:0]  WA;
    logic [31:0] IN;
    logic        WE_L, WE_H;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_wb #(.LDQ_DEPTH(4)) dut (
        .CLK(CLK), .RST(RST),
        .ALU_VALID(ALU_VALID), .ALU_WA(ALU_WA), .ALU_DATA(ALU_DATA), .ALU_HALF(ALU_HALF),
        .LD_ISSUE(LD_ISSUE), .LD_IWA(LD_IWA), .LD_IHALF(LD_IHALF),
        .LD_RVALID(LD_RVALID), .LD_RDATA(LD_RDATA), .LD_RREADY(LD_RREADY),
        .RA0(RA0), .RA1(RA1), .HAZ0(HAZ0), .HAZ1(HAZ1), .ALU_WAW(ALU_WAW),
        .LD_FULL(LD_FULL), .ERR(ERR), .WA(WA), .IN(IN), .WE_L(WE_L), .WE_H(WE_H)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_write(input string tag, input logic [2:0] wa, input logic [31:0] data,
                               input logic we_l, input logic we_h);
        check({tag, ".wa"},   32'(WA),   32'(wa));
        check({tag, ".in"},   IN,        data);
        check({tag, ".we_l"}, 32'(WE_L), 32'(we_l));
        check({tag, ".we_h"}, 32'(WE_H), 32'(we_h));
    endtask

    initial begin
        RST = 1'b1;
        ALU_VALID = 0; ALU_WA = 0; ALU_DATA = 0; ALU_HALF = 0;
        LD_ISSUE = 0; LD_IWA = 0; LD_IHALF = 0;
        LD_RVALID = 0; LD_RDATA = 0; RA0 = 0; RA1 = 0;
        #12;
        check_write("reset", 3'd0, 32'h0, 1'b0, 1'b0);
        check("reset.err",    32'(ERR),       32'd0);
        check("reset.haz0",   32'(HAZ0),      32'd0);
        check("reset.full",   32'(LD_FULL),   32'd0);
        check("reset.rready", 32'(LD_RREADY), 32'd1);
        RST = 1'b0;
        tick();

        // ALU full-word write, visible one edge later, then enables drop
        ALU_VALID = 1; ALU_WA = 3'd3; ALU_DATA = 32'hDEADBEEF; ALU_HALF = 2'b11;
        tick();
        check_write("alu", 3'd3, 32'hDEADBEEF, 1'b1, 1'b1);
        ALU_VALID = 0;
        tick();
        check_write("alu_idle", 3'd3, 32'hDEADBEEF, 1'b0, 1'b0);

        // high-half load to r5
        LD_ISSUE = 1; LD_IWA = 3'd5; LD_IHALF = 2'b10; RA0 = 3'd5;
        #1 check("ld5.haz0_pre", 32'(HAZ0), 32'd0);
        tick();
        LD_ISSUE = 0;
        #1 check("ld5.haz0_pend", 32'(HAZ0), 32'd1);
        LD_RVALID = 1; LD_RDATA = 32'h00001234;
        #1 check("ld5.rready", 32'(LD_RREADY), 32'd1);
        tick();
        LD_RVALID = 0;
        check_write("ld5", 3'd5, 32'h12341234, 1'b0, 1'b1);
        check("ld5.haz0_clr", 32'(HAZ0), 32'd0);

        // ALU wins over a waiting response; load order preserved
        LD_ISSUE = 1; LD_IWA = 3'd2; LD_IHALF = 2'b01;
        tick();
        LD_IWA = 3'd7; LD_IHALF = 2'b11;
        tick();
        LD_ISSUE = 0;
        ALU_VALID = 1; ALU_WA = 3'd1; ALU_DATA = 32'h11111111; ALU_HALF = 2'b11;
        LD_RVALID = 1; LD_RDATA = 32'h0000ABCD;
        #1 check("arb.rready", 32'(LD_RREADY), 32'd0);
        check("arb.waw", 32'(ALU_WAW), 32'd0);
        tick();
        check_write("arb.alu", 3'd1, 32'h11111111, 1'b1, 1'b1);
        ALU_VALID = 0;
        tick();
        check_write("arb.ld2", 3'd2, 32'hABCDABCD, 1'b1, 1'b0);
        LD_RDATA = 32'hCAFEF00D;
        tick();
        check_write("arb.ld7", 3'd7, 32'hCAFEF00D, 1'b1, 1'b1);
        LD_RVALID = 0;
        check("arb.err", 32'(ERR), 32'd0);

        // fill the queue, then an issue while full with a same-cycle pop
        LD_ISSUE = 1; LD_IHALF = 2'b11;
        for (int r = 1; r <= 4; r++) begin
            LD_IWA = 3'(r);
            tick();
        end
        LD_ISSUE = 0;
        check("full.full", 32'(LD_FULL), 32'd1);
        check("full.err",  32'(ERR),     32'd0);
        LD_ISSUE = 1; LD_IWA = 3'd6; LD_RVALID = 1; LD_RDATA = 32'h00000055; RA0 = 3'd6; RA1 = 3'd1;
        tick();
        LD_ISSUE = 0;
        check_write("full.pop1", 3'd1, 32'h00000055, 1'b1, 1'b1);
        check("full.err_set", 32'(ERR),     32'd1);
        check("full.count3",  32'(LD_FULL), 32'd0);
        check("full.drop6",   32'(HAZ0),    32'd0);
        check("full.haz1",    32'(HAZ1),    32'd0);
        LD_RDATA = 32'h00000066;
        tick();
        check("drain.wa2", 32'(WA), 32'd2);
        LD_RDATA = 32'h00000077;
        tick();
        check("drain.wa3", 32'(WA), 32'd3);
        LD_RVALID = 0; RA0 = 3'd4;
        #1 check("drain.haz4", 32'(HAZ0), 32'd1);

        // asynchronous reset mid-queue while a write is in flight
        ALU_VALID = 1; ALU_WA = 3'd6; ALU_DATA = 32'h0BADF00D; ALU_HALF = 2'b11;
        tick();
        ALU_VALID = 0;
        check("rst.we_pre", 32'(WE_L), 32'd1);
        #2 RST = 1'b1;
        #1;
        check_write("rst.async", 3'd0, 32'h0, 1'b0, 1'b0);
        check("rst.haz4", 32'(HAZ0), 32'd0);
        check("rst.err",  32'(ERR),  32'd0);
        #2 RST = 1'b0;
        tick();
        check("rst.no_we", 32'(WE_L | WE_H), 32'd0);

        // response with empty queue: consumed, no write, ERR sticky
        LD_RVALID = 1; LD_RDATA = 32'h99999999;
        #1 check("empty.rready", 32'(LD_RREADY), 32'd1);
        tick();
        LD_RVALID = 0;
        check_write("empty.no_we", 3'd0, 32'h0, 1'b0, 1'b0);
        check("empty.err", 32'(ERR), 32'd1);
        tick();
        check("empty.sticky", 32'(ERR), 32'd1);

        // same-cycle pop and push of r6 keeps r6 pending
        LD_ISSUE = 1; LD_IWA = 3'd6; LD_IHALF = 2'b11; RA1 = 3'd6;
        tick();
        LD_IHALF = 2'b01; LD_RVALID = 1; LD_RDATA = 32'h00000089;
        tick();
        LD_ISSUE = 0; LD_RVALID = 0;
        check_write("pp.pop6", 3'd6, 32'h00000089, 1'b1, 1'b1);
        check("pp.haz1", 32'(HAZ1), 32'd1);
        ALU_VALID = 1; ALU_WA = 3'd6; ALU_DATA = 32'h66666666; ALU_HALF = 2'b11;
        #1 check("pp.waw", 32'(ALU_WAW), 32'd1);
        tick();
        ALU_VALID = 0;
        check_write("pp.alu6", 3'd6, 32'h66666666, 1'b1, 1'b1);
        LD_RVALID = 1; LD_RDATA = 32'h0000BEEF;
        tick();
        LD_RVALID = 0;
        check_write("pp.ld6", 3'd6, 32'hBEEFBEEF, 1'b1, 1'b0);
        check("pp.haz1_clr", 32'(HAZ1), 32'd0);

        // illegal lane encoding is dropped and flagged
        #2 RST = 1'b1;
        #2 RST = 1'b0;
        tick();
        check("ill.err_clr", 32'(ERR), 32'd0);
        LD_ISSUE = 1; LD_IWA = 3'd3; LD_IHALF = 2'b00; RA0 = 3'd3;
        tick();
        LD_ISSUE = 0;
        check("ill.err",  32'(ERR),  32'd1);
        check("ill.haz0", 32'(HAZ0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
